// File: rtl/hog_fetch_ctrl_if.sv
// hog_fetch_ctrl_if: memory-read and neighbourhood-output bundle between the
// fetch sequencer (master) and the frame buffer / hog pipeline (slave).
interface hog_fetch_ctrl_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 13
);
  // Frame buffer read port (single-port memory, one cycle read latency).
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [PIX_W-1:0]     mem_data;

  // Packed neighbourhood stream towards the hog datapath.
  logic                 o_valid;
  logic                 o_ready;
  logic [4*PIX_W-1:0]   o_data;
  logic                 o_last;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    output o_valid,
    input  o_ready,
    output o_data,
    output o_last
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    input  o_valid,
    output o_ready,
    input  o_data,
    input  o_last
  );
endinterface

// File: rtl/hog_fetch_ctrl.sv
// hog_fetch_ctrl: raster-order frame scanner for the hog pipeline.
// For every centre pixel (x,y) the four neighbours are read one per cycle
// (top, bottom, left, right), captured, and presented as one packed word
// {top, bot, left, right} on a valid/ready stream. Six cycles per pixel
// when the consumer is always ready.
//
// Build option HOG_FETCH_REPLICATE_EN:
//   defined   -> out-of-frame neighbours are replaced by the nearest edge
//                pixel (clamped coordinate, read is still issued)
//   undefined -> out-of-frame neighbours are zero (no read is issued)
// Cycle timing is the same in both builds.
module hog_fetch_ctrl #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  hog_fetch_ctrl_if.master bus
);

  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

`ifdef HOG_FETCH_REPLICATE_EN
  // Border neighbours still read memory, at the clamped (own) coordinate.
  localparam logic EDGE_RD = 1'b1;
`else
  // Border neighbours issue no read and are captured as zero.
  localparam logic EDGE_RD = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_T = 3'd1,
    ST_RD_B = 3'd2,
    ST_RD_L = 3'd3,
    ST_RD_R = 3'd4,
    ST_CAP  = 3'd5,
    ST_OUT  = 3'd6
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [X_W-1:0]       x_r;
  logic [X_W-1:0]       x_nxt_s;
  logic [Y_W-1:0]       y_r;
  logic [Y_W-1:0]       y_nxt_s;
  logic                 last_pix_s;
  logic                 handshake_s;

  // Read request for the cycle after the coming edge.
  logic                 rd_nxt_s;
  logic [X_W-1:0]       rd_x_s;
  logic [Y_W-1:0]       rd_y_s;
  logic [ADDR_W-1:0]    addr_nxt_s;

  logic                 mem_rd_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic                 data_vld_r;
  logic [PIX_W-1:0]     cap_pix_s;
  logic [PIX_W-1:0]     top_r;
  logic [PIX_W-1:0]     bot_r;
  logic [PIX_W-1:0]     left_r;
  logic [4*PIX_W-1:0]   o_data_r;
  logic                 o_valid_r;
  logic                 busy_r;
  logic                 done_r;

  // Linear frame-buffer address of pixel (x,y): y*IMG_W + x, unsigned.
  function automatic logic [ADDR_W-1:0] lin_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return (ADDR_W'(y) * ADDR_W'(IMG_W)) + ADDR_W'(x);
  endfunction

  // Scan position and handshake decode: sequence the four reads, then hold
  // OUT until the consumer accepts, then step to the next raster pixel.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    handshake_s = 1'b0;
    last_pix_s  = (x_r == X_MAX) && (y_r == Y_MAX);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RD_T;
          x_nxt_s     = {X_W{1'b0}};
          y_nxt_s     = {Y_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_T: state_nxt_s = ST_RD_B;
      ST_RD_B: state_nxt_s = ST_RD_L;
      ST_RD_L: state_nxt_s = ST_RD_R;
      ST_RD_R: state_nxt_s = ST_CAP;
      ST_CAP:  state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (bus.o_ready) begin
          handshake_s = 1'b1;
          if (last_pix_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RD_T;
            if (x_r == X_MAX) begin
              x_nxt_s = {X_W{1'b0}};
              y_nxt_s = y_r + Y_W'(1);
            end else begin
              x_nxt_s = x_r + X_W'(1);
            end
          end
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        x_nxt_s     = {X_W{1'b0}};
        y_nxt_s     = {Y_W{1'b0}};
      end
    endcase
  end

  // Neighbour read for the upcoming state. Bounds are tested on the centre
  // coordinate before any subtraction, so an address can never wrap. The
  // default neighbour coordinate is the centre itself, which is exactly the
  // clamped coordinate when the neighbour falls off the frame edge.
  always_comb begin
    rd_nxt_s = 1'b0;
    rd_x_s   = x_nxt_s;
    rd_y_s   = y_nxt_s;
    case (state_nxt_s)
      ST_RD_T: begin
        if (y_nxt_s != {Y_W{1'b0}}) begin
          rd_nxt_s = 1'b1;
          rd_y_s   = y_nxt_s - Y_W'(1);
        end else begin
          rd_nxt_s = EDGE_RD;
        end
      end
      ST_RD_B: begin
        if (y_nxt_s != Y_MAX) begin
          rd_nxt_s = 1'b1;
          rd_y_s   = y_nxt_s + Y_W'(1);
        end else begin
          rd_nxt_s = EDGE_RD;
        end
      end
      ST_RD_L: begin
        if (x_nxt_s != {X_W{1'b0}}) begin
          rd_nxt_s = 1'b1;
          rd_x_s   = x_nxt_s - X_W'(1);
        end else begin
          rd_nxt_s = EDGE_RD;
        end
      end
      ST_RD_R: begin
        if (x_nxt_s != X_MAX) begin
          rd_nxt_s = 1'b1;
          rd_x_s   = x_nxt_s + X_W'(1);
        end else begin
          rd_nxt_s = EDGE_RD;
        end
      end
      default: begin
        rd_nxt_s = 1'b0;
      end
    endcase
    if (rd_nxt_s) begin
      addr_nxt_s = lin_addr(rd_x_s, rd_y_s);
    end else begin
      addr_nxt_s = {ADDR_W{1'b0}};
    end
  end

  // Data returning this cycle belongs to last cycle's read; a skipped read
  // (zero-padded border) returns zero instead of whatever the memory holds.
  always_comb begin
    if (data_vld_r) begin
      cap_pix_s = bus.mem_data;
    end else begin
      cap_pix_s = {PIX_W{1'b0}};
    end
  end

  // State and scan coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      x_r     <= {X_W{1'b0}};
      y_r     <= {Y_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
    end
  end

  // Registered control outputs, decoded one cycle ahead from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      data_vld_r <= 1'b0;
      o_valid_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mem_rd_r   <= rd_nxt_s;
      mem_addr_r <= addr_nxt_s;
      data_vld_r <= mem_rd_r;
      o_valid_r  <= (state_nxt_s == ST_OUT);
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= handshake_s && last_pix_s;
    end
  end

  // Neighbour capture: each pixel arrives one state after its read; the
  // right neighbour goes straight into the output word with the other three.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_r    <= {PIX_W{1'b0}};
      bot_r    <= {PIX_W{1'b0}};
      left_r   <= {PIX_W{1'b0}};
      o_data_r <= {(4*PIX_W){1'b0}};
    end else begin
      case (state_r)
        ST_RD_B: top_r    <= cap_pix_s;
        ST_RD_L: bot_r    <= cap_pix_s;
        ST_RD_R: left_r   <= cap_pix_s;
        ST_CAP:  o_data_r <= {top_r, bot_r, left_r, cap_pix_s};
        default: begin
          top_r    <= top_r;
          bot_r    <= bot_r;
          left_r   <= left_r;
          o_data_r <= o_data_r;
        end
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.o_valid  = o_valid_r;
  assign bus.o_data   = o_data_r;
  assign bus.o_last   = (state_r == ST_OUT) && last_pix_s;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_hog_fetch_ctrl.sv
// tb_hog_fetch_ctrl: scoreboard bench for hog_fetch_ctrl on a 4x3 frame whose
// memory word at address a holds a+1. Each accepted start pushes the whole
// frame's expected neighbourhoods, computed from pixel coordinates; a monitor
// pops one entry per output handshake and also watches busy/done/reads.
`timescale 1ns/1ps
module tb_hog_fetch_ctrl;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int NPIX   = IMG_W * IMG_H;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  hog_fetch_ctrl_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  hog_fetch_ctrl #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int start_cnt = 0;
  int fin_cnt = 0;
  int hs_cnt = 0;
  int done_due = -1;
  bit chk_latency = 1'b0;
  logic stall_prev = 1'b0;
  logic [4*PIX_W-1:0] held_data = '0;
  logic [4*PIX_W:0] sb[$];

  // Expected read strobes/addresses in the four read cycles of pixel (0,0).
`ifdef HOG_FETCH_REPLICATE_EN
  int tr_rd[4]   = '{1, 1, 1, 1};
`else
  int tr_rd[4]   = '{0, 1, 0, 1};
`endif
  int tr_addr[4] = '{0, IMG_W, 0, 1};

  // Cycle counter: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer model: word a = a+1, one cycle latency, junk when not read.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= PIX_W'(32'(bus.mem_addr) + 1);
    else            bus.mem_data <= PIX_W'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit frame_open();
    return start_cnt != fin_cnt;
  endfunction

  // Pixel value at (x,y) as seen by the hog datapath, border rule applied.
  function automatic int pix(input int x, input int y);
    int cx;
    int cy;
`ifdef HOG_FETCH_REPLICATE_EN
    cx = (x < 0) ? 0 : (x > IMG_W - 1) ? IMG_W - 1 : x;
    cy = (y < 0) ? 0 : (y > IMG_H - 1) ? IMG_H - 1 : y;
`else
    if (x < 0 || x >= IMG_W || y < 0 || y >= IMG_H) return 0;
    cx = x;
    cy = y;
`endif
    return cy * IMG_W + cx + 1;
  endfunction

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        sb.push_back({(x == IMG_W - 1 && y == IMG_H - 1),
                      PIX_W'(pix(x, y - 1)), PIX_W'(pix(x, y + 1)),
                      PIX_W'(pix(x - 1, y)), PIX_W'(pix(x + 1, y))});
      end
    end
    start_cyc = cyc;
    start_cnt++;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (frame_open() && n < max) begin
      @(posedge clk);
      n++;
    end
    check("frame_timeout", frame_open(), 1'b0);
    repeat (3) @(posedge clk);
  endtask

  // Random consumer backpressure plus stray start pulses while busy.
  task automatic run_random(input int ncyc, input bit stop_idle);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      bus.o_ready = ($urandom % 3) != 0;
      start = frame_open() && (hs_cnt < 9) && (($urandom % 8) == 0);
      if (stop_idle && !frame_open()) break;
    end
    #0 start = 1'b0;
  endtask

  // Monitor: scoreboard pops on handshake, plus per-cycle protocol checks.
  initial begin
    int rel;
    logic [4*PIX_W:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        fin_cnt = start_cnt;
        hs_cnt = 0;
        done_due = -1;
        stall_prev = 1'b0;
        sb.delete();
      end else begin
        rel = cyc - start_cyc;
        check("busy", busy, frame_open());
        check("done", done, cyc == done_due);
        if (frame_open() && rel >= 0 && rel <= 5) begin
          check("first_valid", bus.o_valid, rel == 5);
          if (rel <= 3) begin
            check("trace_rd", bus.mem_rd, tr_rd[rel]);
            check("trace_addr", bus.mem_addr, tr_addr[rel]);
          end
        end
        if (bus.mem_rd) check("addr_range", 32'(bus.mem_addr) < NPIX, 1'b1);
        if (bus.o_valid) check("rd_in_out", bus.mem_rd, 1'b0);
        else check("last_low", bus.o_last, 1'b0);
        if (stall_prev) begin
          check("stall_valid", bus.o_valid, 1'b1);
          check("stall_data", bus.o_data, held_data);
        end
        if (bus.o_valid && bus.o_ready) begin
          hs_cnt++;
          check("sb_has_entry", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("o_data", bus.o_data, exp[4*PIX_W-1:0]);
            check("o_last", bus.o_last, exp[4*PIX_W]);
            if (exp[4*PIX_W]) begin
              check("frame_pixels", hs_cnt, NPIX);
              // done appears NPIX*6 edges after the start-sampling edge.
              if (chk_latency) check("done_latency", cyc + 1 - start_cyc, NPIX * 6);
              done_due = cyc + 1;
              hs_cnt = 0;
              fin_cnt++;
            end
          end
        end
        stall_prev = bus.o_valid && !bus.o_ready;
        held_data = bus.o_data;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int n;
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rd", bus.mem_rd, 1'b0);
      check("idle_valid", bus.o_valid, 1'b0);
      check("idle_data", bus.o_data, '0);
    end

    // Frame 1: always-ready consumer, latency checks.
    chk_latency = 1'b1;
    start_frame();
    wait_idle(200);
    chk_latency = 1'b0;

    // Frame 2: consumer stalls 20 cycles on pixel (2,0); stray start pulse.
    start_frame();
    n = 0;
    while (hs_cnt < 2 && n < 100) begin @(posedge clk); n++; end
    #1 bus.o_ready = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("stall_reached", bus.o_valid, 1'b1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (18) @(posedge clk);
    #1 bus.o_ready = 1'b1;
    wait_idle(300);

    // Frame 3: random backpressure, then reset mid-frame.
    start_frame();
    run_random(30 + int'($urandom % 20), 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd", bus.mem_rd, 1'b0);
    check("rst_addr", bus.mem_addr, '0);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_data", bus.o_data, '0);
    check("rst_last", bus.o_last, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus.o_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Frame 4: full rescan from (0,0) under random backpressure.
    start_frame();
    run_random(600, 1'b1);
    bus.o_ready = 1'b1;
    wait_idle(100);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
